// File: rtl/vga_fb_arbiter_if.sv
// Bus bundle for the framebuffer arbiter: scanout pixel stream, CPU write
// port and the single-port framebuffer RAM port.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              frame_start;
  logic              pix_pop;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              underrun;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  frame_start, pix_pop, cpu_req, cpu_addr, cpu_wdata, mem_rdata,
    output pix_data, pix_valid, underrun, cpu_gnt,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output frame_start, pix_pop, cpu_req, cpu_addr, cpu_wdata, mem_rdata,
    input  pix_data, pix_valid, underrun, cpu_gnt,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: shares one single-port RAM between scanout prefetch
// reads and CPU pixel writes. Scanout is decoupled through a small FIFO so
// the pixel side never stalls on arbitration. Runs entirely on vgaclk.
//
// Arbitration decision (combinational, one access per cycle)
//   decision  | meaning
//   ARB_IDLE  | no RAM access this cycle
//   ARB_READ  | prefetch read at r_rd_addr
//   ARB_WRITE | CPU write, cpu_gnt pulses
module vga_fb_arbiter #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WATER  = 4
) (
  input logic             clk,
  input logic             rst_n,
  vga_fb_arbiter_if.slave bus
);
  localparam int PIX = H_RES * V_RES;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

  typedef enum logic [1:0] {ARB_IDLE, ARB_READ, ARB_WRITE} arb_e;

  logic              r_active;
  logic              r_inflight;
  logic              r_drop;
  logic              r_underrun;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];

  arb_e              w_arb;
  logic [CW:0]       w_occ;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;

  // Occupancy counts the read still in flight so the FIFO can never overflow.
  assign w_occ   = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_empty = (r_count == '0);
  // A return arriving in a frame_start cycle belongs to the old frame.
  assign w_push  = r_inflight && !r_drop && !bus.frame_start;
  assign w_pop   = bus.pix_pop && !w_empty && !bus.frame_start;

  // Arbitration: refill below the low-water mark, then writes, then top-up.
  always_comb begin
    w_arb = ARB_IDLE;
    if (r_active) begin
      if (bus.frame_start) begin
        if (bus.cpu_req) w_arb = ARB_WRITE;
      end else if (w_occ < (CW+1)'(LOW_WATER)) begin
        w_arb = ARB_READ;
      end else if (bus.cpu_req) begin
        w_arb = ARB_WRITE;
      end else if (w_occ < (CW+1)'(FIFO_DEPTH)) begin
        w_arb = ARB_READ;
      end
    end
  end

  // RAM port and handshake outputs follow the decision combinationally.
  always_comb begin
    bus.mem_en    = (w_arb != ARB_IDLE);
    bus.mem_we    = (w_arb == ARB_WRITE);
    bus.cpu_gnt   = (w_arb == ARB_WRITE);
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (w_arb == ARB_WRITE) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (w_arb == ARB_READ) begin
      bus.mem_addr  = r_rd_addr;
    end
  end

  assign bus.pix_valid = !w_empty;
  assign bus.pix_data  = w_empty ? '0 : r_fifo[r_rptr];
  assign bus.underrun  = r_underrun;

  // Control state: scan address, FIFO pointers/count, in-flight tracking.
  // r_active holds off the first read until the cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active   <= 1'b0;
      r_inflight <= 1'b0;
      r_drop     <= 1'b0;
      r_underrun <= 1'b0;
      r_rd_addr  <= '0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_active   <= 1'b1;
      r_inflight <= (w_arb == ARB_READ);
      r_drop     <= bus.frame_start && r_inflight && (w_arb == ARB_READ);
      if (bus.pix_pop && w_empty && !bus.frame_start) r_underrun <= 1'b1;
      if (bus.frame_start) begin
        r_rd_addr <= '0;
        r_count   <= '0;
        r_wptr    <= '0;
        r_rptr    <= '0;
      end else begin
        if (w_arb == ARB_READ)
          r_rd_addr <= (r_rd_addr == ADDR_W'(PIX-1)) ? '0 : r_rd_addr + 1'b1;
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
    end
  end

  // FIFO storage: read data lands one cycle after the read was issued.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= bus.mem_rdata;
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;
  localparam int H_RES = 32;
  localparam int V_RES = 4;
  localparam int PIX   = H_RES * V_RES;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   exp_rd = 0;
  logic [7:0] ram [0:1023];
  logic [7:0] sb_q [$];

  vga_fb_arbiter_if #(.ADDR_W(19), .DATA_W(8)) bus ();

  vga_fb_arbiter #(
    .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(19), .DATA_W(8),
    .FIFO_DEPTH(16), .LOW_WATER(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Framebuffer RAM model, one-cycle read latency.
  always @(posedge clk) begin
    if (rst_n && bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr[9:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= ram[bus.mem_addr[9:0]];
    end
  end

  // Monitor and scoreboard: each read pushes the expected pixel (from the
  // bench's own scan counter), each accepted pop compares against the head.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_rd = 0;
    end else begin
      if (bus.cpu_gnt) begin
        chk("gnt_we", 32'(bus.mem_we), 32'(1));
        chk("wr_addr", 32'(bus.mem_addr), 32'(bus.cpu_addr));
        chk("wr_data", 32'(bus.mem_wdata), 32'(bus.cpu_wdata));
      end
      if (bus.mem_we) chk("we_gnt", 32'(bus.cpu_gnt), 32'(1));
      if (bus.frame_start) begin
        chk("fs_no_read", 32'(bus.mem_en && !bus.mem_we), 32'(0));
        sb_q.delete();
        exp_rd = 0;
      end else begin
        if (bus.pix_pop && bus.pix_valid) begin
          chk("sb_nonempty", 32'(sb_q.size() != 0), 32'(1));
          if (sb_q.size() != 0) chk("pix_data", 32'(bus.pix_data), 32'(sb_q.pop_front()));
        end
        if (bus.mem_en && !bus.mem_we) begin
          chk("rd_addr", 32'(bus.mem_addr), 32'(exp_rd));
          sb_q.push_back(ram[exp_rd]);
          exp_rd = (exp_rd + 1) % PIX;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_en"}, 32'(bus.mem_en), 32'(0));
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'(0));
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(0));
    chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'(0));
    chk({tag, "_cpu_gnt"}, 32'(bus.cpu_gnt), 32'(0));
    chk({tag, "_pix_valid"}, 32'(bus.pix_valid), 32'(0));
    chk({tag, "_pix_data"}, 32'(bus.pix_data), 32'(0));
    chk({tag, "_underrun"}, 32'(bus.underrun), 32'(0));
  endtask

  initial begin
    int g;
    int n;
    bit found;
    for (int i = 0; i < 1024; i++) ram[i] = 8'((i * 37 + 11) & 8'hFF);
    bus.frame_start = 1'b0;
    bus.pix_pop     = 1'b0;
    bus.cpu_req     = 1'b0;
    bus.cpu_addr    = '0;
    bus.cpu_wdata   = '0;
    bus.mem_rdata   = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset state
    @(negedge clk);
    chk_reset_outputs("rst");

    // Fill after reset release: 16 back-to-back reads, then idle
    @(posedge clk); #1 rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.mem_en) found = 1'b1;
    end
    chk("rd_start", 32'(found), 32'(1));
    n = 1;
    repeat (15) begin
      @(negedge clk);
      if (bus.mem_en && !bus.mem_we) n++;
    end
    chk("rd_burst", 32'(n), 32'(16));
    @(negedge clk);
    chk("idle_full", 32'(bus.mem_en), 32'(0));
    chk("valid_full", 32'(bus.pix_valid), 32'(1));
    chk("head_ram0", 32'(bus.pix_data), 32'(ram[0]));

    // Write with FIFO full: granted within one cycle, exactly one pulse
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_addr = 19'h00100; bus.cpu_wdata = 8'hA5;
    g = 0;
    for (int i = 0; i < 2 && g == 0; i++) begin
      @(negedge clk);
      if (bus.cpu_gnt) g++;
      else begin @(posedge clk); #1; end
    end
    @(posedge clk); #1 bus.cpu_req = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.cpu_gnt) g++;
    end
    chk("gnt_once", 32'(g), 32'(1));

    // Streaming pops with a held write request: writes drain occupancy
    // from 16 down to 3 (13 grants), then reads hold it at 3.
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_addr = 19'h00180; bus.cpu_wdata = 8'h5A;
    bus.pix_pop = 1'b1;
    g = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.cpu_gnt) g++;
      @(posedge clk);
    end
    #1 bus.pix_pop = 1'b0; bus.cpu_req = 1'b0;
    chk("stream_gnts", 32'(g), 32'(13));
    chk("stream_underrun", 32'(bus.underrun), 32'(0));

    // frame_start right after the read of address 50
    repeat (20) @(posedge clk);
    #1 bus.pix_pop = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (bus.mem_en && !bus.mem_we && bus.mem_addr == 19'd50) found = 1'b1;
      else @(posedge clk);
    end
    chk("saw_rd50", 32'(found), 32'(1));
    @(posedge clk); #1;
    bus.frame_start = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_addr = 19'h00200; bus.cpu_wdata = 8'h77;
    @(negedge clk);
    chk("fs_gnt", 32'(bus.cpu_gnt), 32'(1));
    @(posedge clk); #1;
    bus.frame_start = 1'b0; bus.pix_pop = 1'b0; bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("fs_flushed", 32'(bus.pix_valid), 32'(0));
    chk("fs_rd_en", 32'(bus.mem_en && !bus.mem_we), 32'(1));
    chk("fs_rd_addr0", 32'(bus.mem_addr), 32'(0));
    repeat (4) @(posedge clk);
    #1 bus.pix_pop = 1'b1;
    @(negedge clk);
    chk("fs_first_pix", 32'(bus.pix_data), 32'(ram[0]));
    @(posedge clk); #1 bus.pix_pop = 1'b0;

    // Underrun: pop while empty right after reset release
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; bus.pix_pop = 1'b1;
    @(negedge clk);
    chk("ur_empty", 32'(bus.pix_valid), 32'(0));
    @(posedge clk); #1 bus.pix_pop = 1'b0;
    @(negedge clk);
    chk("ur_set", 32'(bus.underrun), 32'(1));
    repeat (25) @(posedge clk);
    #1 bus.pix_pop = 1'b1;
    repeat (10) @(posedge clk);
    #1 bus.pix_pop = 1'b0;
    @(negedge clk);
    chk("ur_sticky", 32'(bus.underrun), 32'(1));

    // Mid-frame async reset: outputs clear without a clock edge
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk_reset_outputs("arst");
    @(posedge clk); #1 rst_n = 1'b1;

    chk("ram_w100", 32'(ram[10'h100]), 32'(8'hA5));
    chk("ram_w180", 32'(ram[10'h180]), 32'(8'h5A));
    chk("ram_w200", 32'(ram[10'h200]), 32'(8'h77));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM between VGA scanout reads and CPU (ASIP) pixel writes.
- Scanout is fed through an internal prefetch FIFO so that the pixel clock side never waits on RAM arbitration.
- Sits between the ASIP store path, the framebuffer RAM and videoGen; runs entirely in the vgaclk domain.

Parameters:
- H_RES, 640, active pixels per line.
- V_RES, 480, active lines per frame.
- ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- DATA_W, 8, pixel width (palette index).
- FIFO_DEPTH, 16, prefetch FIFO entries; power of two, >= 4.
- LOW_WATER, 4, occupancy below which reads take absolute priority over writes.

Ports:
- clk  in  1  vgaclk; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse at the start of vertical blank; restarts scanout at address 0.
- pix_pop  in  1  VGA consumes one pixel this cycle (asserted while blank_b=1).
- pix_data  out  DATA_W  FIFO head pixel; valid when pix_valid=1.
- pix_valid  out  1  FIFO non-empty.
- underrun  out  1  sticky; set on pix_pop while the FIFO is empty; cleared only by reset.
- cpu_req  in  1  CPU write request; held until granted.
- cpu_addr  in  ADDR_W  write address.
- cpu_wdata  in  DATA_W  write data.
- cpu_gnt  out  1  one-cycle pulse; the write is issued to RAM this cycle.
- mem_en  out  1  RAM access this cycle.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; valid exactly 1 cycle after a read is issued.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_gnt=0, pix_valid=0, pix_data=0, underrun=0.
  - Internal: rd_addr=0, FIFO count=0, in-flight flag=0, drop flag=0.
  - Reset asserted mid-access aborts it. A pending returning read is discarded.
- Occupancy occ = FIFO count + in-flight (0 or 1). At most one access is issued per cycle; RAM outputs are combinational from the arbitration decision. Arbitration each cycle, in priority order:
  1. occ < LOW_WATER → issue read at rd_addr.
  2. Else if cpu_req → issue write (mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata) and pulse cpu_gnt.
  3. Else if occ < FIFO_DEPTH → issue read.
  4. Else idle (mem_en=0).
- Read issue:
  - rd_addr increments; it wraps from H_RES*V_RES-1 to 0.
  - The in-flight flag is set for the next cycle.
  - The next cycle, mem_rdata is pushed into the FIFO (latency 1), unless the drop flag is set.
- pix_pop:
  - Pops the head when pix_valid=1; pix_data updates the same cycle the pop is registered.
  - Push and pop in the same cycle leave count unchanged.
  - Pop while empty sets underrun and changes nothing else.
- frame_start:
  - FIFO flushed to count 0 and rd_addr reset to 0.
  - Any in-flight read sets the drop flag, so its return is discarded.
  - No read is issued in the frame_start cycle; a CPU write may still be granted that cycle.
  - frame_start has priority over a simultaneous pix_pop; the pop is ignored.
- Fairness:
  - Writes are guaranteed service whenever occ >= LOW_WATER.
  - When the FIFO is full and cpu_req=1, the grant occurs within 1 cycle.
- Write/read hazard: no forwarding. A write to an address already prefetched is not visible until the next frame.

Test Plan:
- Reset release, no pix_pop, cpu_req=0 → reads at addresses 0..15 on consecutive cycles; then mem_en=0; pix_valid=1, pix_data=RAM[0].
- FIFO full, cpu_req=1, cpu_addr=0x00100, cpu_wdata=0xA5 → next cycle mem_we=1, mem_addr=0x00100, mem_wdata=0xA5, cpu_gnt pulses once; cpu_gnt stays 0 while cpu_req=0.
- Continuous pix_pop, 1 pixel/cycle, with cpu_req held high → reads win while occ<4; writes are granted whenever occ>=4; underrun stays 0; popped data equals RAM[0],RAM[1],... in order.
- Run rd_addr to 307199 → next read address is 0 (wrap); no gap in the read sequence.
- frame_start asserted the cycle after a read of address 50 → the returning data is not pushed; count=0; next read is at address 0; the first popped pixel equals RAM[0].
- pix_pop with the FIFO empty (immediately after reset) → underrun=1 and stays 1 through later traffic; it is cleared by an rst_n pulse mid-frame, and all outputs return to reset values asynchronously.
